// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: freezes and flushes the PC and
// inter-stage registers, sequences the SRAM handshake with a timeout, and keeps statistics.
//
// state    | meaning
// RUN      | pipeline flowing; hazard and branch responses applied
// MEM_WAIT | memory access outstanding; pipeline frozen until ready or timeout
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             err_clr,
  input  logic             cnt_clr,
  output logic             pc_freeze,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pipe_freeze,
  output logic             mem_start,
  output logic             mem_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              timeout;
  logic              set_err;

  assign timeout  = (wcnt == WCNT_LAST);
  assign mem_busy = (state == MEM_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    pc_freeze   = 1'b0;
    if_freeze   = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    pipe_freeze = 1'b0;
    mem_start   = 1'b0;
    set_err     = 1'b0;
    case (state)
      RUN: begin
        if (mem_req) begin
          mem_start   = 1'b1;
          pc_freeze   = 1'b1;
          if_freeze   = 1'b1;
          pipe_freeze = 1'b1;
          state_nxt   = MEM_WAIT;
          wcnt_nxt    = '0;
        end else if (branch_taken) begin
          if_flush = 1'b1;
          id_flush = 1'b1;
        end else if (hazard) begin
          pc_freeze = 1'b1;
          if_freeze = 1'b1;
          id_flush  = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready && !timeout) begin
          pc_freeze   = 1'b1;
          if_freeze   = 1'b1;
          pipe_freeze = 1'b1;
          wcnt_nxt    = wcnt + 1'b1;
        end else begin
          // Release (or abort) cycle: a branch held in EXE during the wait lands now.
          state_nxt = RUN;
          wcnt_nxt  = '0;
          set_err   = !mem_ready;
          if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
          end else if (hazard) begin
            pc_freeze = 1'b1;
            if_freeze = 1'b1;
            id_flush  = 1'b1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else if (set_err) begin
      mem_err <= 1'b1;
    end else if (err_clr) begin
      mem_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_freeze && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (if_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors are queued as each cycle
// is driven and popped when the outputs are sampled; counters and error flag are modelled.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  // control vector: {pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze, mem_start}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_HAZ   = 6'b110100;
  localparam logic [5:0] C_BR    = 6'b001100;
  localparam logic [5:0] C_ISSUE = 6'b110011;
  localparam logic [5:0] C_WAIT  = 6'b110010;

  typedef struct {
    logic [5:0] ctl;
    logic       busy;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             hazard, branch_taken, mem_req, mem_ready, err_clr, cnt_clr;
  logic             pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze, mem_start;
  logic             mem_busy, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int   npass  = 0;
  int   ntotal = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;
  logic exp_err = 1'b0;

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .hazard(hazard), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .pc_freeze(pc_freeze), .if_freeze(if_freeze), .if_flush(if_flush),
    .id_flush(id_flush), .pipe_freeze(pipe_freeze), .mem_start(mem_start),
    .mem_busy(mem_busy), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] ctl_vec();
    return {pc_freeze, if_freeze, if_flush, id_flush, pipe_freeze, mem_start};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntotal++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One clock cycle: drive inputs shortly after the rising edge, sample before the next.
  task automatic cyc(input logic hz, input logic br, input logic mr, input logic rdy,
                     input logic ec, input logic cc, input logic [5:0] ectl,
                     input logic ebusy, input logic abort);
    exp_t e;
    hazard = hz; branch_taken = br; mem_req = mr; mem_ready = rdy;
    err_clr = ec; cnt_clr = cc;
    sb.push_back('{ectl, ebusy});
    #4;
    e = sb.pop_front();
    check("ctrl", 32'(ctl_vec()), 32'(e.ctl));
    check("mem_busy", 32'(mem_busy), 32'(e.busy));
    check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    check("mem_err", 32'(mem_err), 32'(exp_err));
    if (cc) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (e.ctl[5] && exp_stall < CNT_MAX) exp_stall++;
      if (e.ctl[3] && exp_flush < CNT_MAX) exp_flush++;
    end
    exp_err = abort ? 1'b1 : (ec ? 1'b0 : exp_err);
    @(posedge clk);
    #1;
  endtask

  task automatic timeout_run(input logic ec_on_abort);
    cyc(0, 0, 1, 0, 0, 0, C_ISSUE, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) cyc(0, 0, 1, 0, 0, 0, C_WAIT, 1, 0);
    cyc(0, 0, 1, 0, ec_on_abort, 0, C_NONE, 1, 1);
  endtask

  initial begin
    rst = 1'b0;
    hazard = 0; branch_taken = 0; mem_req = 0; mem_ready = 0; err_clr = 0; cnt_clr = 0;
    #2;
    check("rst_ctrl", 32'(ctl_vec()), 32'(C_NONE));
    check("rst_busy", 32'(mem_busy), 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    mem_req = 1'b1;
    #1;
    check("rst_req_ctrl", 32'(ctl_vec()), 32'(C_ISSUE));
    check("rst_req_busy", 32'(mem_busy), 32'd0);
    mem_req = 1'b0;
    #9;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // idle
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
    // hazard bubble, two cycles
    cyc(1, 0, 0, 0, 0, 0, C_HAZ, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, C_HAZ, 0, 0);
    // branch beats hazard
    cyc(1, 1, 0, 0, 0, 0, C_BR, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, C_NONE, 0, 0);
    // memory access, ready three cycles after issue, branch held throughout
    cyc(0, 1, 1, 0, 0, 0, C_ISSUE, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, C_WAIT, 1, 0);
    cyc(0, 1, 1, 0, 0, 0, C_WAIT, 1, 0);
    cyc(0, 1, 1, 1, 0, 0, C_BR, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
    // back-to-back minimum-length accesses, second released with a hazard
    cyc(0, 0, 1, 0, 0, 0, C_ISSUE, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, C_NONE, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, C_ISSUE, 0, 0);
    cyc(1, 0, 1, 1, 0, 0, C_HAZ, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, C_NONE, 0, 0);
    // stall counter saturation, clear priority over increment
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0, C_HAZ, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, C_HAZ, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
    // timeout abort, then clear
    timeout_run(1'b0);
    cyc(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, C_NONE, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
    // timeout with clear in the same cycle: set wins
    timeout_run(1'b1);
    cyc(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
    // reset in the middle of a wait
    cyc(0, 0, 1, 0, 0, 0, C_ISSUE, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, C_WAIT, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, C_WAIT, 1, 0);
    mem_req = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(mem_busy), 32'd0);
    check("midrst_err", 32'(mem_err), 32'd0);
    check("midrst_stall", 32'(stall_cnt), 32'd0);
    check("midrst_ctrl", 32'(ctl_vec()), 32'(C_NONE));
    exp_stall = 0; exp_flush = 0; exp_err = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, C_BR, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, C_NONE, 0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
